phy_rx: RTL
===========

PHY_RX -- requirements
Module: phy_rx

Interface
REQ-001 SHALL have port clk_32f  input  1  bit-rate clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_L  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port phy_rx_in_0  input  1  serial lane 0, one bit per clk_32f, MSB first, carries word bits [31:16].
REQ-004 SHALL have port phy_rx_in_1  input  1  serial lane 1, one bit per clk_32f, MSB first, carries word bits [15:0].
REQ-005 SHALL have port data_out  output  32  last received data word.
REQ-006 SHALL have port valid_out  output  1  one-cycle pulse marking a new word on data_out.
REQ-007 SHALL have port active_out  output  1  high while lanes are byte- and word-aligned (state ACTIVE).

Function
REQ-008 SHALL keep a per-lane 8-bit shift register (sr0, sr1) plus a per-lane 16-bit word register, shifting in the lane bit every clock, new bit at LSB.
REQ-009 SHALL implement states HUNT, SYNC and ACTIVE; the COM symbol is 8'hBC.
REQ-010 HUNT: at each edge, if the post-shift sr0 and sr1 both equal 8'hBC -> SYNC, com_cnt=1, bit_cnt=0; otherwise stay in HUNT (bit-level search, any bit offset).
REQ-011 SYNC: bit_cnt increments mod 8; on the edge where bit_cnt==7 (byte boundary), both post-shift bytes == 8'hBC -> com_cnt+1, else -> HUNT with com_cnt=0.
REQ-012 SYNC -> ACTIVE on the edge completing the 4th consecutive COM byte on both lanes; phase counter cleared to 0 on that edge; active_out=1 from that edge.
REQ-013 ACTIVE: 4-bit phase counter increments every clock and wraps 15->0; one word spans phases 0..15.
REQ-014 On the edge where phase==15, the word = {lane0 16 bits, lane1 16 bits} including the bit sampled on that edge.
REQ-015 If both lane halves equal 16'hBCBC the word is idle: valid_out=0, data_out holds; otherwise data_out=word and valid_out=1 for exactly one cycle.
REQ-016 Latency: data_out/valid_out update on the same edge that samples bit 0 of the word (registered output, no combinational path from inputs).
REQ-017 ACTIVE is left only by reset; no loss-of-sync detection in ACTIVE.
REQ-018 Lanes SHALL be assumed skew-free; COM on only one lane never advances SYNC.
REQ-019 A data word of 32'hBCBCBCBC SHALL be treated as idle (transmitter contract excludes it).

Reset
REQ-020 While reset_L==0 at a clock edge: state=HUNT, com_cnt=0, bit_cnt=0, phase=0, shift/word registers=0, data_out=32'h0, valid_out=0, active_out=0.
REQ-021 Reset asserted mid-word SHALL discard the partial word, produce no valid_out pulse, and require full resynchronisation (4 COM bytes) after release.

Configuration
REQ-022 Macro PHY_RX_PIPE_EN: when defined, data_out, valid_out and active_out pass through one extra register stage (all latencies +1 clock, reset values unchanged).
REQ-023 Without PHY_RX_PIPE_EN: timing exactly as REQ-012/REQ-016.

Verification
REQ-024 Hold reset_L=0 for 3 clocks with random lane bits -> data_out=0, valid_out=0, active_out=0.
REQ-025 After reset, 3 random bits then 8'hBC x4 on both lanes -> active_out rises on edge sampling last bit of 4th COM byte, valid_out stays 0.
REQ-026 Synced, send 32'h12345678 (lane0 16'h1234, lane1 16'h5678) -> valid_out=1 one cycle, data_out=32'h12345678 on 16th bit edge (+1 clock with PHY_RX_PIPE_EN).
REQ-027 In SYNC, 3 COM bytes then 8'h00 on lane 1 -> return to HUNT, active_out stays 0.
REQ-028 ACTIVE, idle word 16'hBCBC on both lanes after 32'hA5A5F00F -> valid_out=0, data_out holds 32'hA5A5F00F.
REQ-029 Reset_L pulsed low at phase 7 of a data word -> no valid_out, active_out=0 next edge, resync needed before next word is accepted.

Source files
------------

// File: rtl/phy_rx.sv
// Two-lane serial receiver: COM-symbol alignment (HUNT/SYNC/ACTIVE) and 32-bit word assembly.
// Optional PHY_RX_PIPE_EN adds one output register stage on data_out/valid_out/active_out.
module phy_rx (
    input  logic        clk_32f,
    input  logic        reset_L,
    input  logic        phy_rx_in_0,
    input  logic        phy_rx_in_1,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        active_out
);

    localparam int unsigned SR_W       = 8;
    localparam int unsigned HALF_W     = 16;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BIT_CNT_W  = 3;
    localparam int unsigned COM_CNT_W  = 3;
    localparam int unsigned PHASE_W    = 4;
    localparam int unsigned COM_TARGET = 4;

    localparam logic [SR_W-1:0]   COM       = 8'hBC;
    localparam logic [HALF_W-1:0] IDLE_HALF = 16'hBCBC;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t                 state, state_nx;
    logic [SR_W-1:0]        sr0, sr1, sr0_nx, sr1_nx;
    logic [HALF_W-1:0]      wd0, wd1, wd0_nx, wd1_nx;
    logic [COM_CNT_W-1:0]   com_cnt, com_cnt_nx;
    logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_nx;
    logic [PHASE_W-1:0]     phase, phase_nx;
    logic [WORD_W-1:0]      data_q, data_nx;
    logic                   valid_q, valid_nx;
    logic                   active_q, active_nx;
    logic                   both_com;

    // State and datapath registers
    always_ff @(posedge clk_32f) begin
        if (!reset_L) begin
            state    <= HUNT;
            sr0      <= '0;
            sr1      <= '0;
            wd0      <= '0;
            wd1      <= '0;
            com_cnt  <= '0;
            bit_cnt  <= '0;
            phase    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state    <= state_nx;
            sr0      <= sr0_nx;
            sr1      <= sr1_nx;
            wd0      <= wd0_nx;
            wd1      <= wd1_nx;
            com_cnt  <= com_cnt_nx;
            bit_cnt  <= bit_cnt_nx;
            phase    <= phase_nx;
            data_q   <= data_nx;
            valid_q  <= valid_nx;
            active_q <= active_nx;
        end
    end

    // Next-state logic; alignment decisions use the post-shift lane bytes
    always_comb begin
        sr0_nx     = {sr0[SR_W-2:0], phy_rx_in_0};
        sr1_nx     = {sr1[SR_W-2:0], phy_rx_in_1};
        wd0_nx     = {wd0[HALF_W-2:0], phy_rx_in_0};
        wd1_nx     = {wd1[HALF_W-2:0], phy_rx_in_1};
        state_nx   = state;
        com_cnt_nx = com_cnt;
        bit_cnt_nx = bit_cnt;
        phase_nx   = phase;
        data_nx    = data_q;
        valid_nx   = 1'b0;
        active_nx  = active_q;
        both_com   = (sr0_nx == COM) && (sr1_nx == COM);

        case (state)
            HUNT: begin
                if (both_com) begin
                    state_nx   = SYNC;
                    com_cnt_nx = COM_CNT_W'(1);
                    bit_cnt_nx = '0;
                end
            end
            SYNC: begin
                bit_cnt_nx = BIT_CNT_W'(bit_cnt + BIT_CNT_W'(1));
                if (bit_cnt == BIT_CNT_W'(SR_W - 1)) begin
                    if (both_com) begin
                        com_cnt_nx = COM_CNT_W'(com_cnt + COM_CNT_W'(1));
                        if (com_cnt == COM_CNT_W'(COM_TARGET - 1)) begin
                            state_nx  = ACTIVE;
                            phase_nx  = '0;
                            active_nx = 1'b1;
                        end
                    end else begin
                        state_nx   = HUNT;
                        com_cnt_nx = '0;
                    end
                end
            end
            ACTIVE: begin
                phase_nx = PHASE_W'(phase + PHASE_W'(1));
                // Last bit of the word lands this edge; idle words leave data_out untouched
                if (phase == PHASE_W'(HALF_W - 1)) begin
                    if (!((wd0_nx == IDLE_HALF) && (wd1_nx == IDLE_HALF))) begin
                        data_nx  = {wd0_nx, wd1_nx};
                        valid_nx = 1'b1;
                    end
                end
            end
            default: begin
                state_nx   = HUNT;
                com_cnt_nx = '0;
                bit_cnt_nx = '0;
                phase_nx   = '0;
            end
        endcase
    end

`ifdef PHY_RX_PIPE_EN
    logic [WORD_W-1:0] data_p;
    logic              valid_p;
    logic              active_p;

    // Extra output stage for timing closure
    always_ff @(posedge clk_32f) begin
        if (!reset_L) begin
            data_p   <= '0;
            valid_p  <= 1'b0;
            active_p <= 1'b0;
        end else begin
            data_p   <= data_q;
            valid_p  <= valid_q;
            active_p <= active_q;
        end
    end

    assign data_out   = data_p;
    assign valid_out  = valid_p;
    assign active_out = active_p;
`else
    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign active_out = active_q;
`endif

endmodule
